mem_port_arbiter: RTL

//  Shares the single-port instruction/data memory between the fetch stage (IF) and the load/store unit (LS).

---
 rtl/mem_arb_pkg.sv | 23 ++
 rtl/arb_lat_counter.sv | 34 +++
 rtl/mem_port_arbiter.sv | 133 +++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_IF,
    OWN_LS
  } owner_e;

  typedef enum logic {
    ARB_IDLE,
    ARB_BUSY
  } arb_state_e;

  // Fetches always read a full word
  localparam logic [3:0] FETCH_BE = 4'hF;

  // Width of a counter that must be able to hold the value 'limit'
  function automatic int cnt_width(input int limit);
    return $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/arb_lat_counter.sv
// Saturating up-counter with synchronous clear; 'done' while the count equals LIMIT.
// A clear together with enable counts the current cycle as the first one, so a
// counter cleared on a grant reaches LIMIT exactly LIMIT cycles after that grant.
module arb_lat_counter
  import mem_arb_pkg::*;
#(
  parameter int LIMIT = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic done
);

  localparam int W = cnt_width(LIMIT);
  localparam logic [W-1:0] LIMIT_V = W'(LIMIT);

  logic [W-1:0] count_reg;

  // count enabled cycles, restart on clear, hold at LIMIT
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= enable ? W'(1) : '0;
    end else if (enable && (count_reg != LIMIT_V)) begin
      count_reg <= count_reg + W'(1);
    end
  end

  assign done = (count_reg == LIMIT_V);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port memory between instruction fetch (IF) and the
// load/store unit (LS), one outstanding transaction at a time over a memory
// with fixed read latency MEM_LAT. Grants are combinational in IDLE or in the
// completion cycle, so back-to-back transactions reach full utilisation.
// LS wins over IF; with ARB_STARVE_GUARD_EN defined, IF is forced after
// STARVE_LIMIT consecutive LS grants taken while IF was waiting.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LAT = 1
`ifdef ARB_STARVE_GUARD_EN
  , parameter int STARVE_LIMIT = 4
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_gnt_o,
  output logic        if_rvalid_o,
  output logic [31:0] if_rdata_o,
  input  logic        ls_req_i,
  input  logic        ls_we_i,
  input  logic [3:0]  ls_be_i,
  input  logic [31:0] ls_addr_i,
  input  logic [31:0] ls_wdata_i,
  output logic        ls_gnt_o,
  output logic        ls_rvalid_o,
  output logic [31:0] ls_rdata_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  output logic        busy_o
);

  arb_state_e state_reg;
  owner_e     owner_reg;
  logic       store_reg;

  logic lat_done;
  logic complete;
  logic can_grant;
  logic force_if;
  logic grant_ls;
  logic grant_if;
  logic grant_any;

  // state_reg is forced to IDLE by reset, so completion cannot fire under reset
  assign complete  = (state_reg == ARB_BUSY) && lat_done;
  assign can_grant = !reset && ((state_reg == ARB_IDLE) || complete);
  assign grant_ls  = can_grant && ls_req_i && !(force_if && if_req_i);
  assign grant_if  = can_grant && if_req_i && !grant_ls;
  assign grant_any = grant_ls || grant_if;

  arb_lat_counter #(
    .LIMIT (MEM_LAT)
  ) u_lat_cnt (
    .clk    (clk),
    .reset  (reset),
    .clear  (grant_any),
    .enable (grant_any || (state_reg == ARB_BUSY)),
    .done   (lat_done)
  );

`ifdef ARB_STARVE_GUARD_EN
  logic starve_done;

  arb_lat_counter #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve_cnt (
    .clk    (clk),
    .reset  (reset),
    .clear  (grant_if),
    .enable (grant_ls && if_req_i),
    .done   (starve_done)
  );

  assign force_if = starve_done;
`else
  assign force_if = 1'b0;
`endif

  // transaction FSM: remember owner and kind of the access in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ARB_IDLE;
      owner_reg <= OWN_NONE;
      store_reg <= 1'b0;
    end else if (grant_ls) begin
      state_reg <= ARB_BUSY;
      owner_reg <= OWN_LS;
      store_reg <= ls_we_i;
    end else if (grant_if) begin
      state_reg <= ARB_BUSY;
      owner_reg <= OWN_IF;
      store_reg <= 1'b0;
    end else if (complete) begin
      state_reg <= ARB_IDLE;
      owner_reg <= OWN_NONE;
      store_reg <= 1'b0;
    end
  end

  // grant strobes and memory payload, zeroed whenever nothing is issued
  always_comb begin
    if_gnt_o    = grant_if;
    ls_gnt_o    = grant_ls;
    mem_req_o   = grant_any;
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (grant_ls) begin
      mem_we_o    = ls_we_i;
      mem_be_o    = ls_be_i;
      mem_addr_o  = ls_addr_i;
      mem_wdata_o = ls_we_i ? ls_wdata_i : '0;
    end else if (grant_if) begin
      mem_be_o   = FETCH_BE;
      mem_addr_o = if_addr_i;
    end
  end

  assign if_rvalid_o = complete && (owner_reg == OWN_IF);
  assign ls_rvalid_o = complete && (owner_reg == OWN_LS);
  assign if_rdata_o  = if_rvalid_o ? mem_rdata_i : '0;
  assign ls_rdata_o  = (ls_rvalid_o && !store_reg) ? mem_rdata_i : '0;
  assign busy_o      = (state_reg != ARB_IDLE);

endmodule
